spi_master_ctrl: RTL and testbench

//   SPI master that issues register write/read frames to the gpio_expander SPI slave.

---
 rtl/spi_master_ctrl.sv | 162 ++++++++++++++++
 tb/tb_spi_master_ctrl.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_ctrl.sv
// SPI mode-0 master: one register write/read command per frame, 16-bit MSB-first
// frames on sclk/mosi/ss, and the last data bits of miso returned on a response strobe.
module spi_master_ctrl #(
  parameter int CLK_DIV     = 2,
  parameter int ADDR_WIDTH  = 7,
  parameter int PDATA_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic                   cmd_write,
  input  logic [ADDR_WIDTH-1:0]  cmd_addr,
  input  logic [PDATA_WIDTH-1:0] cmd_wdata,
  output logic                   rsp_valid,
  output logic [PDATA_WIDTH-1:0] rsp_rdata,
  output logic                   busy,
  output logic                   sclk,
  output logic                   mosi,
  input  logic                   miso,
  output logic                   ss,
  output logic [2:0]             dbg_state
);

  localparam int FRAME = 1 + ADDR_WIDTH + PDATA_WIDTH;
  localparam int HCW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BCW   = $clog2(FRAME);
  localparam logic [HCW-1:0] HC_MAX   = HCW'(CLK_DIV - 1);
  localparam logic [BCW-1:0] BIT_LAST = BCW'(FRAME - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LEAD  = 3'd1,
    S_SHIFT = 3'd2,
    S_TRAIL = 3'd3,
    S_GAP   = 3'd4
  } state_t;

  state_t                 state_q, state_d;
  logic [HCW-1:0]         hc_q, hc_d;
  logic [BCW-1:0]         bit_q, bit_d;
  logic                   phase_q, phase_d;
  logic [FRAME-1:0]       tx_q, tx_d;
  logic [PDATA_WIDTH-1:0] rx_q, rx_d;
  logic                   sclk_q, sclk_d;
  logic                   ss_q, ss_d;
  logic                   rsp_valid_q, rsp_valid_d;
  logic [PDATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;

  logic                   accept;
  logic                   step;
  logic [FRAME-1:0]       cmd_frame;

  // Handshake: a command is taken on any rising edge where cmd_valid && cmd_ready;
  // cmd_ready is high only in IDLE, and inputs are sampled on that edge alone.
  assign accept    = cmd_valid && (state_q == S_IDLE);
  assign step      = (hc_q == HC_MAX);
  assign cmd_frame = {cmd_write, cmd_addr, cmd_write ? cmd_wdata : {PDATA_WIDTH{1'b0}}};

  always_comb begin
    state_d     = state_q;
    hc_d        = step ? '0 : hc_q + 1'b1;
    bit_d       = bit_q;
    phase_d     = phase_q;
    tx_d        = tx_q;
    rx_d        = rx_q;
    sclk_d      = sclk_q;
    ss_d        = ss_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    case (state_q)
      S_IDLE: begin
        hc_d = '0;
        if (accept) begin
          tx_d    = cmd_frame;
          ss_d    = 1'b0;
          state_d = S_LEAD;
        end
      end
      S_LEAD: begin
        if (step) begin
          bit_d   = '0;
          phase_d = 1'b0;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (step) begin
          if (!phase_q) begin
            sclk_d  = 1'b1;
            rx_d    = {rx_q[PDATA_WIDTH-2:0], miso};
            phase_d = 1'b1;
          end else begin
            // mosi is the frame MSB, so shifting on the fall presents the next bit
            sclk_d  = 1'b0;
            tx_d    = {tx_q[FRAME-2:0], 1'b0};
            phase_d = 1'b0;
            bit_d   = bit_q + 1'b1;
            if (bit_q == BIT_LAST) state_d = S_TRAIL;
          end
        end
      end
      S_TRAIL: begin
        if (step) begin
          sclk_d  = 1'b0;
          tx_d    = '0;
          ss_d    = 1'b1;
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        if (step) begin
          rsp_valid_d = 1'b1;
          rsp_rdata_d = rx_q;
          state_d     = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        ss_d    = 1'b1;
        sclk_d  = 1'b0;
        tx_d    = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      hc_q        <= '0;
      bit_q       <= '0;
      phase_q     <= 1'b0;
      tx_q        <= '0;
      rx_q        <= '0;
      sclk_q      <= 1'b0;
      ss_q        <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      hc_q        <= hc_d;
      bit_q       <= bit_d;
      phase_q     <= phase_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      sclk_q      <= sclk_d;
      ss_q        <= ss_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign cmd_ready = (state_q == S_IDLE);
  assign busy      = ~cmd_ready;
  assign sclk      = sclk_q;
  assign mosi      = tx_q[FRAME-1];
  assign ss        = ss_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Directed bench for spi_master_ctrl: accept-time scoreboard of frames, read data and
// latency, checked against a mode-0 slave model, plus a CLK_DIV=1 instance.
module tb_spi_master_ctrl;

  logic       clk;
  logic       resetn;
  logic       cmd_valid, cmd_ready, cmd_write;
  logic [6:0] cmd_addr;
  logic [7:0] cmd_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       busy, sclk, mosi, miso, ss;
  logic [2:0] dbg_state;

  logic       c1_valid, c1_ready, c1_write;
  logic [6:0] c1_addr;
  logic [7:0] c1_wdata;
  logic       rsp1_valid;
  logic [7:0] rsp1_rdata;
  logic       busy1, sclk1, mosi1, ss1;
  logic [2:0] dbg_state1;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [15:0] exp_frame_q[$];
  logic [7:0]  exp_rsp_q[$];
  int          acc_q[$];
  int          acc_cnt = 0;
  int          rsp_cnt = 0;

  logic [15:0] slave_word = 16'h0000;
  logic [15:0] slv_sh = 16'h0000;

  logic [15:0] frame_cap = 16'h0000;
  int          rise_cnt = 0;
  int          ss_hi_run = 0;
  int          sclk_ss_viol = 0;
  logic        in_frame = 1'b0;
  logic        prev_ss = 1'b1, prev_sclk = 1'b0, prev_rsp = 1'b0;

  spi_master_ctrl #(.CLK_DIV(2), .ADDR_WIDTH(7), .PDATA_WIDTH(8)) dut (
    .clk(clk), .resetn(resetn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .busy(busy), .sclk(sclk),
    .mosi(mosi), .miso(miso), .ss(ss), .dbg_state(dbg_state)
  );

  spi_master_ctrl #(.CLK_DIV(1), .ADDR_WIDTH(7), .PDATA_WIDTH(8)) dut1 (
    .clk(clk), .resetn(resetn), .cmd_valid(c1_valid), .cmd_ready(c1_ready),
    .cmd_write(c1_write), .cmd_addr(c1_addr), .cmd_wdata(c1_wdata),
    .rsp_valid(rsp1_valid), .rsp_rdata(rsp1_rdata), .busy(busy1), .sclk(sclk1),
    .mosi(mosi1), .miso(1'b0), .ss(ss1), .dbg_state(dbg_state1)
  );

  // clock / reset-independent infrastructure
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // mode-0 slave: first bit valid when ss falls, next bit after each sclk fall
  assign miso = slv_sh[15];
  always @(negedge ss) slv_sh <= slave_word;
  always @(negedge sclk) if (!ss) slv_sh <= {slv_sh[14:0], 1'b0};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // scoreboard push: expected frame, read data and accept edge number
  always @(posedge clk) begin
    if (resetn && cmd_valid && cmd_ready) begin
      exp_frame_q.push_back({cmd_write, cmd_addr, cmd_write ? cmd_wdata : 8'h00});
      exp_rsp_q.push_back(slave_word[7:0]);
      acc_q.push_back(cyc + 1);
      acc_cnt++;
    end
  end

  always @(negedge resetn) in_frame = 1'b0;

  // pin monitor and scoreboard pop
  always @(negedge clk) begin
    logic [31:0] exp_f;
    logic [31:0] exp_r;
    int          lat;
    if (resetn) begin
      if (ss && sclk) sclk_ss_viol++;
      if (!ss && prev_ss) begin
        check("ss_gap_ge_2", 32'(ss_hi_run >= 2), 1);
        in_frame  = 1'b1;
        rise_cnt  = 0;
        frame_cap = 16'h0000;
      end
      if (!ss && sclk && !prev_sclk) begin
        frame_cap = {frame_cap[14:0], mosi};
        rise_cnt++;
      end
      if (ss && !prev_ss && in_frame) begin
        exp_f = (exp_frame_q.size() > 0) ? 32'(exp_frame_q.pop_front()) : 32'hDEAD0000;
        check("frame_mosi", 32'(frame_cap), exp_f);
        check("frame_rises", rise_cnt, 16);
        in_frame = 1'b0;
      end
      ss_hi_run = ss ? ss_hi_run + 1 : 0;
      if (prev_rsp) check("rsp_one_cycle", rsp_valid, 0);
      if (rsp_valid) begin
        exp_r = (exp_rsp_q.size() > 0) ? 32'(exp_rsp_q.pop_front()) : 32'h100;
        lat   = (acc_q.size() > 0) ? acc_q.pop_front() : -100000;
        check("rsp_rdata", 32'(rsp_rdata), exp_r);
        check("rsp_latency", cyc - lat, 70);
        rsp_cnt++;
      end
    end
    prev_ss   = ss;
    prev_sclk = sclk;
    prev_rsp  = rsp_valid;
  end

  // driver tasks: called at a negedge, return at the negedge after the accept edge
  task automatic send(input logic w, input logic [6:0] a, input logic [7:0] d);
    int n = 0;
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
    while (!cmd_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("send_accept_in_time", 32'(n < 300), 1);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int target);
    int n = 0;
    while (rsp_cnt < target && n < 400) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("rsp_count", rsp_cnt, target);
  endtask

  int          n, acc0, acc1, last_rise, rises1;
  logic        p1, done;
  logic [15:0] fr1;

  initial begin
    resetn = 1'b0;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    c1_valid = 1'b0; c1_write = 1'b0; c1_addr = '0; c1_wdata = '0;
    repeat (3) @(negedge clk);
    check("reset_ss", ss, 1);
    check("reset_sclk", sclk, 0);
    check("reset_mosi", mosi, 0);
    check("reset_rsp_valid", rsp_valid, 0);
    check("reset_rsp_rdata", 32'(rsp_rdata), 0);
    check("reset_cmd_ready", cmd_ready, 1);
    check("reset_busy", busy, 0);
    check("reset_state", 32'(dbg_state), 0);
    check("reset_ss1", ss1, 1);
    check("reset_sclk1", sclk1, 0);
    resetn = 1'b1;
    repeat (2) @(negedge clk);

    // 1: write 0x20/0x81 -> 0xA081
    slave_word = 16'h1234;
    send(1'b1, 7'h20, 8'h81);
    check("t1_busy_after_accept", busy, 1);
    wait_rsp(1);
    repeat (3) @(negedge clk);
    check("t1_rdata_held", 32'(rsp_rdata), 32'h34);

    // 2: read 0x20, wdata must not leak into the frame -> 0x2000, rdata 0x81
    slave_word = 16'h0081;
    send(1'b0, 7'h20, 8'hFF);
    wait_rsp(2);
    check("t2_rdata", 32'(rsp_rdata), 32'h81);

    // 3: cmd_valid held while addr changes; one frame per accept
    slave_word = 16'h00C3;
    acc0 = acc_cnt;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 7'h11; cmd_wdata = 8'h00;
    @(negedge clk);
    n = 0;
    while (!rsp_valid && n < 200) begin
      cmd_addr = 7'($urandom_range(64, 127));
      @(negedge clk);
      n++;
    end
    check("t3_rsp_seen", rsp_valid, 1);
    check("t3_ready_in_rsp_cycle", cmd_ready, 1);
    @(negedge clk);
    check("t3_second_accepted", busy, 1);
    cmd_valid = 1'b0;
    check("t3_accept_count", acc_cnt - acc0, 2);
    wait_rsp(4);

    // 4: two back-to-back writes
    slave_word = 16'h5AA5;
    send(1'b1, 7'h7F, 8'hFF);
    send(1'b1, 7'h01, 8'h00);
    wait_rsp(6);

    // 5: async reset after the 5th sclk rise, then a clean frame
    slave_word = 16'h00E7;
    send(1'b1, 7'h33, 8'h5A);
    n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (rise_cnt < 5 && n < 200);
    check("t5_reached_5_rises", rise_cnt, 5);
    resetn = 1'b0;
    #1;
    check("t5_async_ss", ss, 1);
    check("t5_async_sclk", sclk, 0);
    check("t5_async_mosi", mosi, 0);
    check("t5_async_ready", cmd_ready, 1);
    exp_frame_q.delete();
    exp_rsp_q.delete();
    acc_q.delete();
    #1;
    resetn = 1'b1;
    repeat (100) @(negedge clk);
    check("t5_no_rsp_after_reset", rsp_cnt, 6);
    slave_word = 16'h3C96;
    send(1'b1, 7'h55, 8'hA7);
    wait_rsp(7);
    check("t5_rdata_after_reset", 32'(rsp_rdata), 32'h96);

    // 6: CLK_DIV=1 instance, write 0x05/0x3C -> 0x853C, sclk period 2, latency 35
    check("t6_ready", c1_ready, 1);
    c1_valid = 1'b1; c1_write = 1'b1; c1_addr = 7'h05; c1_wdata = 8'h3C;
    acc1 = cyc + 1;
    @(negedge clk);
    c1_valid = 1'b0;
    fr1 = 16'h0000; rises1 = 0; last_rise = -1; p1 = 1'b0; done = 1'b0; n = 0;
    while (!done && n < 100) begin
      if (sclk1 && !p1) begin
        if (last_rise >= 0) check("t6_sclk_period", cyc - last_rise, 2);
        last_rise = cyc;
        rises1++;
        fr1 = {fr1[14:0], mosi1};
      end
      if (rsp1_valid) begin
        check("t6_latency", cyc - acc1, 35);
        done = 1'b1;
      end
      p1 = sclk1;
      @(negedge clk);
      n++;
    end
    check("t6_rsp_seen", done, 1);
    check("t6_frame", 32'(fr1), 32'h853C);
    check("t6_rises", rises1, 16);
    check("t6_ss_idle", ss1, 1);

    repeat (5) @(negedge clk);
    check("final_sclk_low_when_ss_high", sclk_ss_viol, 0);
    check("final_frames_drained", exp_frame_q.size(), 0);
    check("final_rsps_drained", exp_rsp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
